// File: rtl/cpu_bus_mux.sv
// Table-driven memory decoder and response mux between the picorv32 native port and N slaves.
// Adds app-mode access protection, bounded slave wait with timeout, and registered ready/rdata.
module cpu_bus_mux #(
  parameter int                               NUM_SLAVES          = 8,
  parameter int                               PREFIX_MSB          = 31,
  parameter int                               PREFIX_LSB          = 24,
  parameter logic [NUM_SLAVES*(PREFIX_MSB-PREFIX_LSB+1)-1:0] SLAVE_PREFIXES = '0,
  parameter logic [NUM_SLAVES-1:0]            APP_ACCESS          = '1,
  parameter int                               TIMEOUT_CYCLES      = 255,
  parameter logic [31:0]                      ILLEGAL_INSTRUCTION = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_valid,
  input  logic                    cpu_instr,
  input  logic [31:0]             cpu_addr,
  input  logic [3:0]              cpu_wstrb,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  input  logic                    force_trap,
  input  logic                    system_mode,
  output logic [NUM_SLAVES-1:0]   slv_cs,
  output logic [4*NUM_SLAVES-1:0] slv_we,
  output logic [31:0]             slv_addr,
  output logic [31:0]             slv_wdata,
  input  logic [32*NUM_SLAVES-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]   slv_ready,
  output logic                    access_violation,
  output logic                    timeout
);

  localparam int PREFIX_W = PREFIX_MSB - PREFIX_LSB + 1;
  localparam int IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] sel_idx;
  logic [3:0]       sel_wstrb;
  logic [CNT_W-1:0] cnt;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  logic             cs_en;
  logic [IDX_W-1:0] cs_idx;
  logic [3:0]       we_val;
  logic             accept;
  logic             latch;
  logic [31:0]      latch_val;
  logic             viol_d;
  logic             to_d;

  // The fetch flag is carried on the port for future decode use only.
  logic unused_instr;
  assign unused_instr = cpu_instr;

  assign slv_addr  = cpu_addr;
  assign slv_wdata = cpu_wdata;

  // Descending scan so the lowest matching index is the last one assigned.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (cpu_addr[PREFIX_MSB:PREFIX_LSB] == SLAVE_PREFIXES[i*PREFIX_W +: PREFIX_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    next_state = state;
    cs_en      = 1'b0;
    cs_idx     = sel_idx;
    we_val     = sel_wstrb;
    accept     = 1'b0;
    latch      = 1'b0;
    latch_val  = '0;
    viol_d     = 1'b0;
    to_d       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cpu_valid) begin
          if (force_trap) begin
            latch      = 1'b1;
            latch_val  = ILLEGAL_INSTRUCTION;
            next_state = ST_DONE;
          end else if (!hit) begin
            latch      = 1'b1;
            next_state = ST_DONE;
          end else if (!system_mode && !APP_ACCESS[hit_idx]) begin
            latch      = 1'b1;
            viol_d     = 1'b1;
            next_state = ST_DONE;
          end else begin
            cs_en  = 1'b1;
            cs_idx = hit_idx;
            we_val = cpu_wstrb;
            accept = 1'b1;
            if (slv_ready[hit_idx]) begin
              latch      = 1'b1;
              latch_val  = slv_rdata[int'(hit_idx)*32 +: 32];
              next_state = ST_DONE;
            end else begin
              next_state = ST_WAIT;
            end
          end
        end
      end

      ST_WAIT: begin
        cs_en = 1'b1;
        if (slv_ready[sel_idx]) begin
          latch      = 1'b1;
          latch_val  = slv_rdata[int'(sel_idx)*32 +: 32];
          next_state = ST_DONE;
        end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
          latch      = 1'b1;
          to_d       = 1'b1;
          next_state = ST_DONE;
        end
      end

      ST_DONE: next_state = ST_IDLE;

      default: next_state = ST_IDLE;
    endcase
  end

  // Selects are forced low while reset is asserted, without waiting for a clock edge.
  always_comb begin
    slv_cs = '0;
    slv_we = '0;
    if (cs_en && !reset) begin
      slv_cs[cs_idx]              = 1'b1;
      slv_we[int'(cs_idx)*4 +: 4] = we_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      sel_idx          <= '0;
      sel_wstrb        <= '0;
      cnt              <= '0;
      cpu_ready        <= 1'b0;
      cpu_rdata        <= '0;
      access_violation <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state            <= next_state;
      cpu_ready        <= (next_state == ST_DONE);
      access_violation <= viol_d;
      timeout          <= to_d;
      if (latch) cpu_rdata <= latch_val;
      if (accept) begin
        sel_idx   <= hit_idx;
        sel_wstrb <= cpu_wstrb;
        cnt       <= '0;
      end else if (state == ST_WAIT && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_mux.sv
// Directed self-checking bench for cpu_bus_mux: decode, wait, timeout, protection, trap, async reset.
module tb_cpu_bus_mux;

  localparam int NS = 8;
  localparam logic [31:0] ILL = 32'hDEAD_0013;

  logic          clk;
  logic          reset;
  logic          cpu_valid;
  logic          cpu_instr;
  logic [31:0]   cpu_addr;
  logic [3:0]    cpu_wstrb;
  logic [31:0]   cpu_wdata;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic          force_trap;
  logic          system_mode;
  logic [NS-1:0] slv_cs;
  logic [4*NS-1:0] slv_we;
  logic [31:0]   slv_addr;
  logic [31:0]   slv_wdata;
  logic [32*NS-1:0] slv_rdata;
  logic [NS-1:0] slv_ready;
  logic          access_violation;
  logic          timeout;

  int n_checks = 0;
  int n_errors = 0;

  // 6-bit prefixes on addr[29:24]; slave 6 duplicates slave 2's prefix to exercise priority.
  cpu_bus_mux #(
    .NUM_SLAVES(NS),
    .PREFIX_MSB(29),
    .PREFIX_LSB(24),
    .SLAVE_PREFIXES({6'h08, 6'h03, 6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01}),
    .APP_ACCESS(8'b1101_1111),
    .TIMEOUT_CYCLES(4),
    .ILLEGAL_INSTRUCTION(ILL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_valid(cpu_valid),
    .cpu_instr(cpu_instr),
    .cpu_addr(cpu_addr),
    .cpu_wstrb(cpu_wstrb),
    .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata),
    .force_trap(force_trap),
    .system_mode(system_mode),
    .slv_cs(slv_cs),
    .slv_we(slv_we),
    .slv_addr(slv_addr),
    .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata),
    .slv_ready(slv_ready),
    .access_violation(access_violation),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] addr, input logic [3:0] wstrb);
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    cpu_wstrb = wstrb;
    cpu_wdata = 32'h1234_5678;
  endtask

  task automatic idle_bus();
    cpu_valid  = 1'b0;
    force_trap = 1'b0;
    slv_ready  = '0;
    step();
  endtask

  initial begin
    reset       = 1'b1;
    cpu_valid   = 1'b0;
    cpu_instr   = 1'b0;
    cpu_addr    = '0;
    cpu_wstrb   = '0;
    cpu_wdata   = '0;
    force_trap  = 1'b0;
    system_mode = 1'b1;
    slv_ready   = '0;
    // Slave i returns 0xA5A4FFFF + i, so slave 2 -> A5A50001, 3 -> A5A50002, 5 -> A5A50004.
    for (int i = 0; i < NS; i++) slv_rdata[32*i +: 32] = 32'hA5A4_FFFF + 32'(i);

    #2;
    check("rst_ready", {31'b0, cpu_ready}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_pulses", {30'b0, access_violation, timeout}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Immediate-ready read of slave 2; slave 6 shares the prefix and must lose.
    slv_ready = 8'h04;
    req(32'hC300_0010, 4'b0000);
    #1;
    check("rd_cs_accept", {24'b0, slv_cs}, 32'h04);
    check("rd_addr_pass", slv_addr, 32'hC300_0010);
    check("rd_ready_early", {31'b0, cpu_ready}, 32'd0);
    step();
    check("rd_ready", {31'b0, cpu_ready}, 32'd1);
    check("rd_rdata", cpu_rdata, 32'hA5A5_0001);
    check("rd_done_no_cs", {24'b0, slv_cs}, 32'h0);
    step();
    check("rd_no_reissue", {31'b0, cpu_ready}, 32'd0);
    cpu_valid = 1'b0;
    step();
    check("rd_rdata_hold", cpu_rdata, 32'hA5A5_0001);

    // Write to slave 3 with ready raised in the third WAIT cycle.
    slv_ready = '0;
    req(32'h0400_0020, 4'b0011);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) slv_ready = 8'h08;
      #1;
      check($sformatf("wr_we_c%0d", c), slv_we, 32'h0000_3000);
      check($sformatf("wr_cs_c%0d", c), {24'b0, slv_cs}, 32'h08);
      check($sformatf("wr_ready_c%0d", c), {31'b0, cpu_ready}, 32'd0);
      step();
    end
    check("wr_ready", {31'b0, cpu_ready}, 32'd1);
    check("wr_rdata", cpu_rdata, 32'hA5A5_0002);
    idle_bus();
    check("wr_single_pulse", {31'b0, cpu_ready}, 32'd0);

    // Slave 0 never answers: timeout after TIMEOUT_CYCLES+1 edges.
    req(32'h0100_0000, 4'b0000);
    for (int c = 1; c <= 5; c++) begin
      #1;
      check($sformatf("to_cs_c%0d", c), {24'b0, slv_cs}, 32'h01);
      check($sformatf("to_early_c%0d", c), {30'b0, cpu_ready, timeout}, 32'd0);
      step();
    end
    check("to_ready", {31'b0, cpu_ready}, 32'd1);
    check("to_pulse", {31'b0, timeout}, 32'd1);
    check("to_rdata", cpu_rdata, 32'd0);
    check("to_cs_low", {24'b0, slv_cs}, 32'h0);
    idle_bus();
    check("to_pulse_end", {30'b0, cpu_ready, timeout}, 32'd0);

    // Slave 5 in firmware mode reaches the slave.
    system_mode = 1'b1;
    slv_ready   = 8'h20;
    req(32'h0600_0004, 4'b0000);
    #1;
    check("sys_cs", {24'b0, slv_cs}, 32'h20);
    step();
    check("sys_rdata", cpu_rdata, 32'hA5A5_0004);
    check("sys_no_viol", {31'b0, access_violation}, 32'd0);
    idle_bus();

    // Same access in app mode is blocked.
    system_mode = 1'b0;
    slv_ready   = 8'h20;
    req(32'h0600_0004, 4'b0000);
    #1;
    check("viol_no_cs", {24'b0, slv_cs}, 32'h0);
    step();
    check("viol_ready", {31'b0, cpu_ready}, 32'd1);
    check("viol_pulse", {31'b0, access_violation}, 32'd1);
    check("viol_rdata", cpu_rdata, 32'd0);
    idle_bus();
    check("viol_pulse_end", {31'b0, access_violation}, 32'd0);
    system_mode = 1'b1;

    // Forced trap on a valid hit.
    slv_ready  = 8'h04;
    force_trap = 1'b1;
    req(32'hC300_0010, 4'b0000);
    #1;
    check("trap_no_cs", {24'b0, slv_cs}, 32'h0);
    step();
    check("trap_ready", {31'b0, cpu_ready}, 32'd1);
    check("trap_rdata", cpu_rdata, ILL);
    check("trap_no_pulses", {30'b0, access_violation, timeout}, 32'd0);
    idle_bus();

    // Unmapped prefix 0x3E.
    req(32'h3E00_0000, 4'b0000);
    #1;
    check("miss_no_cs", {24'b0, slv_cs}, 32'h0);
    step();
    check("miss_ready", {31'b0, cpu_ready}, 32'd1);
    check("miss_rdata", cpu_rdata, 32'd0);
    check("miss_no_pulses", {30'b0, access_violation, timeout}, 32'd0);
    idle_bus();

    // Load nonzero rdata, then reset asynchronously in WAIT.
    slv_ready = 8'h04;
    req(32'hC300_0010, 4'b0000);
    step();
    idle_bus();
    check("pre_rst_rdata", cpu_rdata, 32'hA5A5_0001);
    req(32'h0200_0000, 4'b1111);
    step();
    check("wait_cs", {24'b0, slv_cs}, 32'h02);
    #2;
    reset = 1'b1;
    #1;
    check("arst_cs", {24'b0, slv_cs}, 32'h0);
    check("arst_we", slv_we, 32'h0);
    check("arst_ready", {31'b0, cpu_ready}, 32'd0);
    check("arst_rdata", cpu_rdata, 32'd0);
    check("arst_pulses", {30'b0, access_violation, timeout}, 32'd0);
    cpu_valid = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Fresh decode from IDLE after release.
    slv_ready = 8'h04;
    req(32'hC300_0010, 4'b0000);
    #1;
    check("post_rst_cs", {24'b0, slv_cs}, 32'h04);
    step();
    check("post_rst_ready", {31'b0, cpu_ready}, 32'd1);
    check("post_rst_rdata", cpu_rdata, 32'hA5A5_0001);
    idle_bus();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
